// File: rtl/avsddac_pkg.sv
// Shared definitions for the RVMyth-to-adacc01 DAC sample sequencer.
package avsddac_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  localparam int DW_DEF = 10;
  localparam int UCNT_W = 8;

endpackage

// File: rtl/avsddac_sfifo.sv
// Synchronous FIFO with flush; head word is visible on rdata whenever non-empty.
module avsddac_sfifo
  import avsddac_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic [DW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/avsddac_seq_ctrl.sv
// DAC sample sequencer: power-up settle window, then paced FIFO drain onto D.
module avsddac_seq_ctrl
  import avsddac_pkg::*;
#(
  parameter int DW            = DW_DEF,
  parameter int DEPTH         = 4,
  parameter int DIV_W         = 16,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cfg_en,
  input  logic [DIV_W-1:0]        cfg_div,
  input  logic                    s_valid,
  input  logic [DW-1:0]           s_data,
  output logic                    s_ready,
  output logic                    dac_en,
  output logic [DW-1:0]           dac_d,
  output logic                    underrun,
  output logic [UCNT_W-1:0]       underrun_cnt,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic [1:0]              state
);

  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t           st;
  logic [SCW-1:0]   settle_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [DW-1:0]    fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic             go_off;
  logic             tick;
  logic             push;
  logic             pop;

  function automatic logic [UCNT_W-1:0] sat_inc(input logic [UCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign go_off  = (st != ST_OFF) && !cfg_en;
  assign tick    = (st == ST_RUN) && cfg_en && (div_cnt == '0);
  assign push    = s_valid && s_ready;
  assign pop     = tick && !fifo_empty;
  assign s_ready = (st != ST_OFF) && !fifo_full;
  assign dac_en  = (st != ST_OFF);
  assign state   = st;

  // A push on the power-down edge is discarded because the flush takes priority.
  avsddac_sfifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (go_off),
    .push    (push),
    .wdata   (s_data),
    .pop     (pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st           <= ST_OFF;
      settle_cnt   <= '0;
      div_cnt      <= '0;
      dac_d        <= '0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      underrun <= 1'b0;
      case (st)
        ST_OFF: begin
          dac_d <= '0;
          if (cfg_en) begin
            st         <= ST_SETTLE;
            settle_cnt <= SCW'(SETTLE_CYCLES - 1);
          end
        end
        ST_SETTLE: begin
          if (!cfg_en) begin
            st           <= ST_OFF;
            dac_d        <= '0;
            underrun_cnt <= '0;
          end else if (settle_cnt == '0) begin
            st      <= ST_RUN;
            div_cnt <= cfg_div;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        ST_RUN: begin
          if (!cfg_en) begin
            st           <= ST_OFF;
            dac_d        <= '0;
            underrun_cnt <= '0;
          end else if (tick) begin
            div_cnt <= cfg_div;
            if (!fifo_empty) begin
              dac_d <= fifo_rdata;
            end else begin
              underrun     <= 1'b1;
              underrun_cnt <= sat_inc(underrun_cnt);
            end
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        default: begin
          st    <= ST_OFF;
          dac_d <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avsddac_seq_ctrl.sv
// Directed bench for avsddac_seq_ctrl with hand-computed expectations.
module tb_avsddac_seq_ctrl;

  localparam int DW    = 10;
  localparam int DEPTH = 4;
  localparam int DIV_W = 16;
  localparam int SC    = 8;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    cfg_en;
  logic [DIV_W-1:0]        cfg_div;
  logic                    s_valid;
  logic [DW-1:0]           s_data;
  logic                    s_ready;
  logic                    dac_en;
  logic [DW-1:0]           dac_d;
  logic                    underrun;
  logic [7:0]              underrun_cnt;
  logic [$clog2(DEPTH):0]  fifo_level;
  logic [1:0]              state;

  int vectors    = 0;
  int miscompares = 0;
  logic seen_ur;

  always #5 clk = ~clk;

  avsddac_seq_ctrl #(
    .DW            (DW),
    .DEPTH         (DEPTH),
    .DIV_W         (DIV_W),
    .SETTLE_CYCLES (SC)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cfg_en       (cfg_en),
    .cfg_div      (cfg_div),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .dac_en       (dac_en),
    .dac_d        (dac_d),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt),
    .fifo_level   (fifo_level),
    .state        (state)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      seen_ur = seen_ur | underrun;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    seen_ur = 1'b0;
    reset_n = 1'b0;
    cfg_en  = 1'b1;
    cfg_div = 16'd9;
    s_valid = 1'b1;
    s_data  = 10'h155;
    cyc(3);
    chk("rst_dac_en", 32'(dac_en), 0);
    chk("rst_dac_d", 32'(dac_d), 0);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_ucnt", 32'(underrun_cnt), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_state", 32'(state), 0);

    // Release and enter SETTLE
    reset_n = 1'b1;
    s_valid = 1'b0;
    cyc(1);
    chk("rel_state", 32'(state), 1);
    chk("rel_dac_en", 32'(dac_en), 1);
    chk("rel_s_ready", 32'(s_ready), 1);

    // Preload four codes during SETTLE
    seen_ur = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = 10'h3FA + 10'(i);
      cyc(1);
    end
    s_valid = 1'b0;
    chk("pre_level", 32'(fifo_level), 4);
    chk("pre_s_ready", 32'(s_ready), 0);
    chk("pre_state", 32'(state), 1);
    cyc(3);
    chk("settle_last", 32'(state), 1);
    cyc(1);
    chk("run_entry", 32'(state), 2);
    cyc(9);
    chk("before_tick1", 32'(dac_d), 0);
    cyc(1);
    chk("tick1_d", 32'(dac_d), 32'h3FA);
    chk("tick1_level", 32'(fifo_level), 3);
    for (int k = 1; k < 4; k++) begin
      cyc(9);
      chk("hold_d", 32'(dac_d), 32'h3FA + 32'(k - 1));
      cyc(1);
      chk("tick_d", 32'(dac_d), 32'h3FA + 32'(k));
    end
    chk("drain_level", 32'(fifo_level), 0);
    chk("no_underrun", 32'(seen_ur), 0);
    chk("no_ucnt", 32'(underrun_cnt), 0);

    // Underrun: single word then empty ticks at period 5
    s_valid = 1'b1;
    s_data  = 10'h3FE;
    cfg_div = 16'd4;
    cyc(1);
    s_valid = 1'b0;
    chk("ur_level1", 32'(fifo_level), 1);
    cyc(8);
    chk("ur_before", 32'(dac_d), 32'h3FD);
    cyc(1);
    chk("ur_pop_d", 32'(dac_d), 32'h3FE);
    chk("ur_pop_flag", 32'(underrun), 0);
    cyc(4);
    chk("ur_quiet", 32'(underrun), 0);
    cyc(1);
    chk("ur_pulse1", 32'(underrun), 1);
    chk("ur_cnt1", 32'(underrun_cnt), 1);
    chk("ur_hold_d", 32'(dac_d), 32'h3FE);
    cyc(1);
    chk("ur_one_cycle", 32'(underrun), 0);
    cyc(4);
    chk("ur_pulse2", 32'(underrun), 1);
    chk("ur_cnt2", 32'(underrun_cnt), 2);
    cyc(5 * 253);
    chk("ur_cnt255", 32'(underrun_cnt), 255);
    cyc(5 * 50);
    chk("ur_sat", 32'(underrun_cnt), 255);
    chk("ur_sat_pulse", 32'(underrun), 1);
    chk("ur_sat_d", 32'(dac_d), 32'h3FE);

    // Power down mid-run with entries queued
    s_valid = 1'b1;
    s_data  = 10'h3FF;
    cyc(1);
    s_valid = 1'b0;
    cyc(4);
    chk("pd_d3ff", 32'(dac_d), 32'h3FF);
    s_valid = 1'b1;
    s_data = 10'h011; cyc(1);
    s_data = 10'h022; cyc(1);
    s_data = 10'h033; cyc(1);
    s_valid = 1'b0;
    chk("pd_level3", 32'(fifo_level), 3);
    cfg_en = 1'b0;
    cyc(1);
    chk("pd_dac_en", 32'(dac_en), 0);
    chk("pd_dac_d", 32'(dac_d), 0);
    chk("pd_level", 32'(fifo_level), 0);
    chk("pd_ucnt", 32'(underrun_cnt), 0);
    chk("pd_s_ready", 32'(s_ready), 0);
    chk("pd_state", 32'(state), 0);
    cfg_div = 16'd9;
    cfg_en  = 1'b1;
    cyc(1);
    chk("re_settle", 32'(state), 1);
    cyc(7);
    chk("re_settle_last", 32'(state), 1);
    cyc(1);
    chk("re_run", 32'(state), 2);
    chk("re_level", 32'(fifo_level), 0);

    // Divider change 9 -> 2 mid-period
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = 10'h101 + 10'(i);
      cyc(1);
    end
    s_valid = 1'b0;
    cfg_div = 16'd2;
    cyc(6);
    chk("div_old_hold", 32'(dac_d), 0);
    cyc(1);
    chk("div_tick1", 32'(dac_d), 32'h101);
    cyc(2);
    chk("div_hold", 32'(dac_d), 32'h101);
    cyc(1);
    chk("div_tick2", 32'(dac_d), 32'h102);
    cyc(3);
    chk("div_tick3", 32'(dac_d), 32'h103);

    // Push into empty FIFO on a tick cycle
    cyc(2);
    s_valid = 1'b1;
    s_data  = 10'h2AA;
    cyc(1);
    s_valid = 1'b0;
    chk("sim_underrun", 32'(underrun), 1);
    chk("sim_level", 32'(fifo_level), 1);
    chk("sim_hold_d", 32'(dac_d), 32'h103);
    chk("sim_ucnt", 32'(underrun_cnt), 1);
    cyc(3);
    chk("sim_next_d", 32'(dac_d), 32'h2AA);
    chk("sim_next_ur", 32'(underrun), 0);

    // Full backpressure with a long divider, drained after a faster reload
    cfg_en  = 1'b0;
    cfg_div = 16'hFFFF;
    cyc(1);
    chk("bp_off", 32'(state), 0);
    cfg_en = 1'b1;
    cyc(1);
    s_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_data = 10'h301 + 10'(i);
      cyc(1);
      chk("bp_level", 32'(fifo_level), (i < 4) ? 32'(i + 1) : 32'd4);
      chk("bp_s_ready", 32'(s_ready), (i < 3) ? 32'd1 : 32'd0);
    end
    s_valid = 1'b0;
    cfg_div = 16'd1;
    cyc(2);
    chk("bp_run", 32'(state), 2);
    for (int k = 0; k < 4; k++) begin
      cyc(2);
      chk("bp_drain", 32'(dac_d), 32'h301 + 32'(k));
    end
    cyc(2);
    chk("bp_no_extra_ur", 32'(underrun), 1);
    chk("bp_no_extra_d", 32'(dac_d), 32'h304);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
